b8b10_lanes: RTL and testbench

- Parametrised multi-lane 8b/10b encoder: encodes LANES bytes per cycle, data or control (K) characters.
- A single running disparity (RD) is chained lane-to-lane within a word and carried across words.
- Valid/ready handshake on both sides, with one registered output stage.
- Sits between the crossbar egress datapath and the serialiser; successor to the single-byte encoder.

---
 rtl/b8b10_lanes.sv | 142 ++++++++++++++
 tb/tb_b8b10_lanes.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/b8b10_lanes.sv
// Multi-lane 8b/10b encoder with a running disparity chained across lanes and words.
// Optional idle K28.5 insertion when nothing is offered: define B8B10_LANES_IDLE_EN.
module b8b10_lanes #(
  parameter int LANES   = 4,
  parameter bit RD_INIT = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [8*LANES-1:0]    data,
  input  logic [LANES-1:0]      k_ctrl,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [10*LANES-1:0]   encoded_out,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [LANES-1:0]      code_err,
  output logic                  rd_out
);

  // Returns {rd_after, abcdei}; the table holds the RD- form of each code.
  function automatic logic [6:0] enc6(input logic [4:0] x, input logic k28, input logic rd);
    logic [5:0] c;
    logic       bal;
    c = 6'b000000;
    if (k28) c = 6'b001111;
    else begin
      case (x)
        5'd0:  c = 6'b100111;  5'd1:  c = 6'b011101;  5'd2:  c = 6'b101101;  5'd3:  c = 6'b110001;
        5'd4:  c = 6'b110101;  5'd5:  c = 6'b101001;  5'd6:  c = 6'b011001;  5'd7:  c = 6'b111000;
        5'd8:  c = 6'b111001;  5'd9:  c = 6'b100101;  5'd10: c = 6'b010101;  5'd11: c = 6'b110100;
        5'd12: c = 6'b001101;  5'd13: c = 6'b101100;  5'd14: c = 6'b011100;  5'd15: c = 6'b010111;
        5'd16: c = 6'b011011;  5'd17: c = 6'b100011;  5'd18: c = 6'b010011;  5'd19: c = 6'b110010;
        5'd20: c = 6'b001011;  5'd21: c = 6'b101010;  5'd22: c = 6'b011010;  5'd23: c = 6'b111010;
        5'd24: c = 6'b110011;  5'd25: c = 6'b100110;  5'd26: c = 6'b010110;  5'd27: c = 6'b110110;
        5'd28: c = 6'b001110;  5'd29: c = 6'b101110;  5'd30: c = 6'b011110;  default: c = 6'b101011;
      endcase
    end
    bal = ($countones(c) == 3);
    if (rd && (!bal || (x == 5'd7 && !k28))) c = ~c;
    return {bal ? rd : ~rd, c};
  endfunction

  // Returns {rd_after, fghj}; K28 uses its own table, every K entry flips at RD+.
  function automatic logic [4:0] enc4(input logic [2:0] y, input logic k28, input logic a7,
                                      input logic rd);
    logic [3:0] c;
    logic       bal;
    logic       flip;
    c = 4'b0000;
    if (k28) begin
      case (y)
        3'd0: c = 4'b1011;  3'd1: c = 4'b0110;  3'd2: c = 4'b1010;  3'd3: c = 4'b1100;
        3'd4: c = 4'b1101;  3'd5: c = 4'b0101;  3'd6: c = 4'b1001;  default: c = 4'b0111;
      endcase
    end else begin
      case (y)
        3'd0: c = 4'b1011;  3'd1: c = 4'b1001;  3'd2: c = 4'b0101;  3'd3: c = 4'b1100;
        3'd4: c = 4'b1101;  3'd5: c = 4'b1010;  3'd6: c = 4'b0110;
        default: c = a7 ? 4'b0111 : 4'b1110;
      endcase
    end
    bal  = ($countones(c) == 2);
    flip = k28 ? rd : (rd && (!bal || y == 3'd3));
    if (flip) c = ~c;
    return {bal ? rd : ~rd, c};
  endfunction

  logic                 rd_q;
  logic                 accept;
  logic                 idle_load;
  logic                 load;
  logic [8*LANES-1:0]   enc_data;
  logic [LANES-1:0]     enc_k;
  logic [10*LANES-1:0]  enc_word;
  logic [LANES-1:0]     enc_err;
  logic [LANES:0]       rd_chain;

  assign in_ready = rst && enable && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

`ifdef B8B10_LANES_IDLE_EN
  assign idle_load = rst && enable && out_ready && !in_valid;
`else
  assign idle_load = 1'b0;
`endif

  assign load     = accept || idle_load;
  assign enc_data = idle_load ? {LANES{8'hBC}} : data;
  assign enc_k    = idle_load ? {LANES{1'b1}} : k_ctrl;

  always_comb begin
    logic [4:0] x;
    logic [2:0] y;
    logic       legal;
    logic       use_k;
    logic       k28;
    logic       a7;
    logic [6:0] r6;
    logic [4:0] r4;
    enc_word    = '0;
    enc_err     = '0;
    rd_chain    = '0;
    rd_chain[0] = rd_q;
    for (int n = 0; n < LANES; n++) begin
      x     = enc_data[8*n +: 5];
      y     = enc_data[8*n+5 +: 3];
      legal = (x == 5'd28) ||
              (y == 3'd7 && (x == 5'd23 || x == 5'd27 || x == 5'd29 || x == 5'd30));
      use_k = enc_k[n] && legal;
      k28   = use_k && (x == 5'd28);
      r6    = enc6(x, k28, rd_chain[n]);
      // Non-28 K codes are D.x.7 forced onto the alternate 3b/4b code.
      a7    = (use_k && !k28) ||
              (!r6[6] && (x == 5'd17 || x == 5'd18 || x == 5'd20)) ||
              ( r6[6] && (x == 5'd11 || x == 5'd13 || x == 5'd14));
      r4    = enc4(y, k28, a7, r6[6]);
      enc_word[10*n +: 10] = {r6[5:0], r4[3:0]};
      enc_err[n]           = enc_k[n] && !legal;
      rd_chain[n+1]        = r4[4];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      encoded_out <= '0;
      code_err    <= '0;
      out_valid   <= 1'b0;
      rd_q        <= RD_INIT;
    end else if (load) begin
      encoded_out <= enc_word;
      code_err    <= enc_err;
      out_valid   <= 1'b1;
      rd_q        <= rd_chain[LANES];
    end else if (out_valid && out_ready) begin
      out_valid   <= 1'b0;
    end
  end

  assign rd_out = rd_q;

endmodule

// File: tb/tb_b8b10_lanes.sv
// Directed scoreboard bench for b8b10_lanes (LANES=4, RD_INIT=0, idle insertion off).
module tb_b8b10_lanes;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [31:0] data;
  logic [3:0]  k_ctrl;
  logic        in_valid;
  logic        in_ready;
  logic [39:0] encoded_out;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  code_err;
  logic        rd_out;

  typedef struct {
    logic [39:0] enc;
    logic [3:0]  err;
    logic        rd;
  } exp_t;

  exp_t exp_q[$];
  int   cmp_cnt = 0;
  int   err_cnt = 0;

  b8b10_lanes #(.LANES(4), .RD_INIT(1'b0)) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .data        (data),
    .k_ctrl      (k_ctrl),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .encoded_out (encoded_out),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .code_err    (code_err),
    .rd_out      (rd_out)
  );

  always #5 clk = ~clk;

  localparam logic [39:0] W1_ENC = {10'b1010101010, 10'b1010101010, 10'b1010101010, 10'b0011111010};
  localparam logic [39:0] W2_ENC = {10'b0011111010, 10'b1100000101, 10'b0011111010, 10'b1100000101};
  localparam logic [39:0] W3_ENC = {4{10'b0110001011}};
  localparam logic [39:0] W5_ENC = {10'b1001110001, 10'b1000110001, 10'b1000110111, 10'b1101001000};
  localparam logic [39:0] W6_ENC = {4{10'b1110101000}};
  localparam logic [39:0] W7_ENC = {4{10'b1110001001}};
  localparam logic [39:0] W8_ENC = {10'b1100000101, 10'b0011111010, 10'b1100000101, 10'b0011111010};
  localparam logic [39:0] D0_ENC = {4{10'b1001110100}};

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    cmp_cnt++;
    assert (obs === expv) else begin
      err_cnt++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // One cycle: drive at negedge, score any consumed word, queue the expectation of an accepted one.
  task automatic applyStimulus(input logic v, input logic [31:0] d, input logic [3:0] k,
                               input logic ordy, input logic [39:0] e_enc,
                               input logic [3:0] e_err, input logic e_rd);
    exp_t item;
    @(negedge clk);
    in_valid  = v;
    data      = d;
    k_ctrl    = k;
    out_ready = ordy;
    #1;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_word", 64'(out_valid), 64'd0);
      end else begin
        item = exp_q.pop_front();
        checkOutput("encoded_out", 64'(encoded_out), 64'(item.enc));
        checkOutput("code_err", 64'(code_err), 64'(item.err));
        checkOutput("rd_out", 64'(rd_out), 64'(item.rd));
      end
    end
    if (in_valid && in_ready) exp_q.push_back('{e_enc, e_err, e_rd});
    @(posedge clk);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b0; enable = 1'b1; in_valid = 1'b0; out_ready = 1'b1; data = '0; k_ctrl = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset_encoded", 64'(encoded_out), 64'd0);
    checkOutput("reset_code_err", 64'(code_err), 64'd0);
    checkOutput("reset_rd_out", 64'(rd_out), 64'd0);
    checkOutput("reset_in_ready", 64'(in_ready), 64'd0);
    rst = 1'b1;
    #1;
    checkOutput("release_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);

    applyStimulus(1'b1, 32'hB5B5B5BC, 4'b0001, 1'b1, W1_ENC, 4'b0000, 1'b1);
    applyStimulus(1'b1, 32'hBCBCBCBC, 4'b1111, 1'b1, W2_ENC, 4'b0000, 1'b1);
    applyStimulus(1'b1, 32'h00000000, 4'b0000, 1'b1, W3_ENC, 4'b0000, 1'b1);
    applyStimulus(1'b1, 32'h00000000, 4'b0100, 1'b1, W3_ENC, 4'b0100, 1'b1);
    applyStimulus(1'b1, 32'hE0F1F1EB, 4'b0000, 1'b1, W5_ENC, 4'b0000, 1'b0);

    // Backpressure: W5 sits in the output register while W6 is offered.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid  = 1'b1;
      data      = 32'hF7F7F7F7;
      k_ctrl    = 4'b1111;
      out_ready = 1'b0;
      #1;
      checkOutput("stall_in_ready", 64'(in_ready), 64'd0);
      checkOutput("stall_encoded", 64'(encoded_out), 64'(W5_ENC));
      checkOutput("stall_rd_out", 64'(rd_out), 64'd0);
      @(posedge clk);
    end

    applyStimulus(1'b1, 32'hF7F7F7F7, 4'b1111, 1'b1, W6_ENC, 4'b0000, 1'b0);
    applyStimulus(1'b1, 32'h27272727, 4'b0000, 1'b1, W7_ENC, 4'b0000, 1'b0);
    applyStimulus(1'b1, 32'hBCBCBCBC, 4'b1111, 1'b1, W8_ENC, 4'b0000, 1'b0);

    // Mid-stream reset: W8 is held and must be discarded.
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rst       = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #1;
    checkOutput("midreset_out_valid", 64'(out_valid), 64'd0);
    checkOutput("midreset_encoded", 64'(encoded_out), 64'd0);
    checkOutput("midreset_rd_out", 64'(rd_out), 64'd0);
    exp_q.delete();
    rst = 1'b1;
    @(posedge clk);

    applyStimulus(1'b1, 32'h00000000, 4'b0000, 1'b1, D0_ENC, 4'b0000, 1'b0);
    for (int i = 0; i < 4; i++)
      applyStimulus(1'b0, 32'h0, 4'b0000, 1'b1, 40'h0, 4'b0000, 1'b0);
    checkOutput("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
